// File: rtl/risc_pkg.sv
// Shared core types: memory access size, LSU bridge state, byte-enable decode.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package risc_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RSP  = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Halfwords need an even address, words a 4-byte aligned one; the
    // unused size encoding is treated as a word.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return offset[0];
            default:  return (offset != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input mem_size_t size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return BE_BYTE << offset;
            MEM_HALF: return offset[1] ? BE_HALF_HI : BE_HALF_LO;
            default:  return BE_WORD;
        endcase
    endfunction

    // Replicate right-justified store data across all lanes so the byte
    // enables alone select the written bytes.
    function automatic logic [31:0] lane_data(input mem_size_t size, input logic [31:0] wr_data);
        case (size)
            MEM_BYTE: return {4{wr_data[7:0]}};
            MEM_HALF: return {2{wr_data[15:0]}};
            default:  return wr_data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: shifts the addressed lane down and sign/zero extends it.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure datapath.
module lsu_load_align
    import risc_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  offset,
    input  logic        zero_ext,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Bring the addressed byte/halfword to bit 0, then extend per size.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = rdata;
        case (size)
            MEM_BYTE: data = {{24{~zero_ext & shifted[7]}},  shifted[7:0]};
            MEM_HALF: data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Bridges the core load/store port onto a req/gnt + rvalid system bus.
// Latency: min 3 stall cycles (IDLE, REQ, RSP) with result in the 4th (DONE).
// Backpressure: core stalled until rvalid or RSP timeout; bus fields held until gnt.
module lsu_bus_bridge
    import risc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dmem_req,
    input  logic        dmem_wr_en,
    input  mem_size_t   dmem_size,
    input  logic        dmem_zero_extend,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wr_data,
    output logic [31:0] dmem_rd_data,
    output logic        dmem_stall,
    output logic        dmem_misaligned,
    output logic        dmem_err,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t    state;
    logic [CW-1:0] cnt;
    mem_size_t     size_q;
    logic [1:0]    offset_q;
    logic          zext_q;
    logic [31:0]   load_data;
    logic          req_misaligned;

    assign req_misaligned = is_misaligned(dmem_size, dmem_addr[1:0]);

    // Misalignment is only reported while a request is being accepted.
    assign dmem_misaligned = (state == LSU_IDLE) && dmem_req && req_misaligned;

    // Stall is raised combinationally on an accepted request so the core
    // freezes in the same cycle; reset masks it immediately.
    assign dmem_stall = reset_n &&
                        (((state == LSU_IDLE) && dmem_req && !req_misaligned) ||
                         (state == LSU_REQ) || (state == LSU_RSP));

    lsu_load_align u_load_align (
        .size     (size_q),
        .offset   (offset_q),
        .zero_ext (zext_q),
        .rdata    (bus_rdata),
        .data     (load_data)
    );

    // Transaction FSM: latch request, drive bus until gnt, await response or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= LSU_IDLE;
            cnt          <= '0;
            size_q       <= MEM_BYTE;
            offset_q     <= 2'b00;
            zext_q       <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_be       <= 4'h0;
            bus_wdata    <= 32'h0;
            dmem_rd_data <= 32'h0;
            dmem_err     <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (dmem_req && !req_misaligned) begin
                        state     <= LSU_REQ;
                        size_q    <= dmem_size;
                        offset_q  <= dmem_addr[1:0];
                        zext_q    <= dmem_zero_extend;
                        bus_req   <= 1'b1;
                        bus_we    <= dmem_wr_en;
                        bus_addr  <= {dmem_addr[31:2], 2'b00};
                        bus_be    <= byte_enables(dmem_size, dmem_addr[1:0]);
                        bus_wdata <= lane_data(dmem_size, dmem_wr_data);
                    end
                end
                LSU_REQ: begin
                    if (bus_gnt) begin
                        state   <= LSU_RSP;
                        bus_req <= 1'b0;
                        cnt     <= '0;
                    end
                end
                LSU_RSP: begin
                    // A response arriving on the expiry cycle still wins.
                    if (bus_rvalid) begin
                        state        <= LSU_DONE;
                        dmem_err     <= bus_err;
                        dmem_rd_data <= (bus_we || bus_err) ? 32'h0 : load_data;
                    end else if (cnt == CNT_LAST) begin
                        state        <= LSU_DONE;
                        dmem_err     <= 1'b1;
                        dmem_rd_data <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE lasts one cycle; result is cleared on leaving it.
                    state        <= LSU_IDLE;
                    dmem_err     <= 1'b0;
                    dmem_rd_data <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
module tb_lsu_bus_bridge;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dmem_req;
    logic        dmem_wr_en;
    mem_size_t   dmem_size;
    logic        dmem_zero_extend;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic [31:0] dmem_rd_data;
    logic        dmem_stall;
    logic        dmem_misaligned;
    logic        dmem_err;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int vectors     = 0;
    int miscompares = 0;

    // Observations gathered by one access
    int          n_stall;
    int          n_req;
    logic        done;
    logic [31:0] r_rd;
    logic        r_err;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_addr;
    logic        r_we;

    lsu_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .dmem_req         (dmem_req),
        .dmem_wr_en       (dmem_wr_en),
        .dmem_size        (dmem_size),
        .dmem_zero_extend (dmem_zero_extend),
        .dmem_addr        (dmem_addr),
        .dmem_wr_data     (dmem_wr_data),
        .dmem_rd_data     (dmem_rd_data),
        .dmem_stall       (dmem_stall),
        .dmem_misaligned  (dmem_misaligned),
        .dmem_err         (dmem_err),
        .bus_req          (bus_req),
        .bus_gnt          (bus_gnt),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_be           (bus_be),
        .bus_wdata        (bus_wdata),
        .bus_rvalid       (bus_rvalid),
        .bus_rdata        (bus_rdata),
        .bus_err          (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one access from a negedge; gnt is given in REQ cycle gnt_wait
    // (0-based), rvalid in RSP cycle rsp_wait (negative = never).
    task automatic access(input logic we, input mem_size_t sz, input logic zx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gnt_wait, input int rsp_wait,
                          input logic [31:0] rdata, input logic berr);
        int  rsp_idx = 0;
        bit  granted = 0;
        n_stall = 0;
        n_req   = 0;
        done    = 1'b0;
        r_rd = 'x; r_err = 'x; r_be = 'x; r_wdata = 'x; r_addr = 'x; r_we = 'x;
        @(negedge clk);
        dmem_req = 1'b1; dmem_wr_en = we; dmem_size = sz; dmem_zero_extend = zx;
        dmem_addr = addr; dmem_wr_data = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
            if (dmem_stall) n_stall++;
            else begin
                r_rd = dmem_rd_data; r_err = dmem_err; done = 1'b1;
                dmem_req = 1'b0;
            end
            if (bus_req) begin
                n_req++;
                r_be = bus_be; r_wdata = bus_wdata; r_addr = bus_addr; r_we = bus_we;
                if (n_req - 1 == gnt_wait) begin
                    bus_gnt = 1'b1;
                    granted = 1;
                end
            end else if (granted && dmem_stall) begin
                if (rsp_idx == rsp_wait) begin
                    bus_rvalid = 1'b1; bus_rdata = rdata; bus_err = berr;
                end
                rsp_idx++;
            end
            @(negedge clk);
        end
        dmem_req = 1'b0;
        chk("access_completed", {31'h0, done}, 32'h1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        dmem_req = 1'b0; dmem_wr_en = 1'b0; dmem_size = MEM_WORD; dmem_zero_extend = 1'b0;
        dmem_addr = 32'h0; dmem_wr_data = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_stall",   {31'h0, dmem_stall},      32'h0);
        chk("rst_bus_req", {31'h0, bus_req},         32'h0);
        chk("rst_rd_data", dmem_rd_data,             32'h0);
        chk("rst_err",     {31'h0, dmem_err},        32'h0);
        chk("rst_misal",   {31'h0, dmem_misaligned}, 32'h0);
        chk("rst_be",      {28'h0, bus_be},          32'h0);
        reset_n = 1'b1;

        // LW 0x100, minimum latency
        access(1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        chk("lw_addr",  r_addr,              32'h100);
        chk("lw_be",    {28'h0, r_be},       32'hF);
        chk("lw_we",    {31'h0, r_we},       32'h0);
        chk("lw_stall", n_stall,             32'd3);
        chk("lw_req",   n_req,               32'd1);
        chk("lw_rd",    r_rd,                32'hDEADBEEF);
        chk("lw_err",   {31'h0, r_err},      32'h0);
        #1 chk("idle_rd_cleared", dmem_rd_data, 32'h0);

        // LB 0x103 sign / zero extended
        access(1'b0, MEM_BYTE, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, 1'b0);
        chk("lb_be",   {28'h0, r_be}, 32'h8);
        chk("lb_addr", r_addr,        32'h100);
        chk("lb_rd",   r_rd,          32'hFFFFFF80);
        access(1'b0, MEM_BYTE, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, 1'b0);
        chk("lbu_rd",  r_rd,          32'h00000080);

        // LH 0x102 sign extended, LHU 0x100
        access(1'b0, MEM_HALF, 1'b0, 32'h102, 32'h0, 1, 2, 32'h80FF_1234, 1'b0);
        chk("lh_be",    {28'h0, r_be}, 32'hC);
        chk("lh_rd",    r_rd,          32'hFFFF80FF);
        chk("lh_stall", n_stall,       32'd6);
        access(1'b0, MEM_HALF, 1'b1, 32'h100, 32'h0, 0, 0, 32'h1234_F00D, 1'b0);
        chk("lhu_be",   {28'h0, r_be}, 32'h3);
        chk("lhu_rd",   r_rd,          32'h0000F00D);

        // SH 0x202, grant after 3 cycles
        access(1'b1, MEM_HALF, 1'b0, 32'h202, 32'h1234ABCD, 3, 0, 32'h5555_5555, 1'b0);
        chk("sh_req_cycles", n_req,          32'd4);
        chk("sh_be",         {28'h0, r_be},  32'hC);
        chk("sh_wdata",      r_wdata,        32'hABCDABCD);
        chk("sh_we",         {31'h0, r_we},  32'h1);
        chk("sh_addr",       r_addr,         32'h200);
        chk("sh_rd_zero",    r_rd,           32'h0);
        chk("sh_stall",      n_stall,        32'd6);

        // SB 0x201, SW 0x300
        access(1'b1, MEM_BYTE, 1'b0, 32'h201, 32'h000000EE, 0, 0, 32'h0, 1'b0);
        chk("sb_be",    {28'h0, r_be}, 32'h2);
        chk("sb_wdata", r_wdata,       32'hEEEEEEEE);
        access(1'b1, MEM_WORD, 1'b0, 32'h300, 32'hCAFEF00D, 0, 0, 32'h0, 1'b0);
        chk("sw_be",    {28'h0, r_be}, 32'hF);
        chk("sw_wdata", r_wdata,       32'hCAFEF00D);

        // Misaligned accesses never reach the bus
        @(negedge clk);
        dmem_req = 1'b1; dmem_wr_en = 1'b0; dmem_size = MEM_WORD; dmem_addr = 32'h101;
        #1;
        chk("mis_w_flag",  {31'h0, dmem_misaligned}, 32'h1);
        chk("mis_w_stall", {31'h0, dmem_stall},      32'h0);
        @(negedge clk);
        chk("mis_w_busreq", {31'h0, bus_req}, 32'h0);
        dmem_size = MEM_HALF; dmem_addr = 32'h203;
        #1;
        chk("mis_h_flag",  {31'h0, dmem_misaligned}, 32'h1);
        @(negedge clk);
        chk("mis_h_busreq", {31'h0, bus_req}, 32'h0);
        dmem_req = 1'b0;
        #1 chk("mis_flag_clear", {31'h0, dmem_misaligned}, 32'h0);

        // Timeout: 4 RSP cycles without rvalid
        access(1'b0, MEM_WORD, 1'b0, 32'h400, 32'h0, 0, -1, 32'h0, 1'b0);
        chk("to_err",   {31'h0, r_err}, 32'h1);
        chk("to_rd",    r_rd,           32'h0);
        chk("to_stall", n_stall,        32'd6);

        // Bus error with rvalid
        access(1'b0, MEM_WORD, 1'b0, 32'h404, 32'h0, 0, 1, 32'h1111_2222, 1'b1);
        chk("berr_err", {31'h0, r_err}, 32'h1);
        chk("berr_rd",  r_rd,           32'h0);

        // rvalid on the expiry cycle wins
        access(1'b0, MEM_WORD, 1'b0, 32'h408, 32'h0, 0, 3, 32'h0BAD_CAFE, 1'b0);
        chk("edge_err", {31'h0, r_err}, 32'h0);
        chk("edge_rd",  r_rd,           32'h0BADCAFE);

        // Reset mid-transaction in RSP
        @(negedge clk);
        dmem_req = 1'b1; dmem_wr_en = 1'b0; dmem_size = MEM_WORD; dmem_addr = 32'h500;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1 chk("rsp_stall_pre", {31'h0, dmem_stall}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_bus_req", {31'h0, bus_req},    32'h0);
        chk("arst_stall",   {31'h0, dmem_stall}, 32'h0);
        dmem_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777; bus_err = 1'b1;
        #1 chk("late_rv_stall", {31'h0, dmem_stall}, 32'h0);
        @(negedge clk);
        bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("late_rv_rd",     dmem_rd_data,       32'h0);
        chk("late_rv_err",    {31'h0, dmem_err},  32'h0);
        chk("late_rv_busreq", {31'h0, bus_req},   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
